// File: rtl/flash_arbiter.sv
// Shares one asynchronous-mode parallel flash between the cartridge ROM read path and the save engine.
// Reads win arbitration by default; a starvation counter forces a save grant after STARVE_MAX passed-over reads.
module flash_arbiter #(
   parameter int RD_WAIT    = 4,
   parameter int WR_PULSE   = 3,
   parameter int RECOVER    = 1,
   parameter int STARVE_MAX = 8
) (
   input  logic        I_CLK,
   input  logic        I_RESET,
   input  logic        I_RD_REQ,
   input  logic [23:0] I_RD_ADDR,
   output logic [15:0] O_RD_DATA,
   output logic        O_RD_ACK,
   input  logic        I_SV_REQ,
   input  logic        I_SV_WE,
   input  logic [23:0] I_SV_ADDR,
   input  logic [15:0] I_SV_WDATA,
   output logic [15:0] O_SV_RDATA,
   output logic        O_SV_ACK,
   inout  wire  [15:0] IO_FLASH_DATA,
   output logic [23:0] O_FLASH_ADDR,
   output logic        O_FLASH_CLK,
   output logic        O_ADDR_VALID_L,
   output logic        O_FLASH_CE_L,
   output logic        O_FLASH_OE_L,
   output logic        O_FLASH_WE_L,
   output logic        O_BUSY
);

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_RD_WAIT, S_WR_PULSE, S_WR_HOLD, S_RECOVER
   } state_t;

   localparam logic [7:0] C_RD_LAST  = 8'(RD_WAIT - 1);
   localparam logic [7:0] C_WR_LAST  = 8'(WR_PULSE - 1);
   localparam logic [7:0] C_RC_LAST  = 8'(RECOVER - 1);
   localparam logic [7:0] C_STARVE   = 8'(STARVE_MAX);

   state_t      r_state, w_next;
   logic [7:0]  r_cnt, r_starve, w_starve_next;
   logic        r_is_sv, r_is_wr;
   logic [23:0] r_addr;
   logic [15:0] r_wdata;
   logic        w_grant, w_grant_sv, w_new_wr, w_sample;
   logic        r_ce_l, r_oe_l, r_we_l, r_adv_l, r_drive, r_busy, r_rd_ack, r_sv_ack;
   logic [15:0] r_rd_data, r_sv_rdata;

   always_comb begin
      w_next        = r_state;
      w_grant       = 1'b0;
      w_grant_sv    = 1'b0;
      w_starve_next = r_starve;
      case (r_state)
         S_IDLE: begin
            if (I_SV_REQ && (r_starve == C_STARVE)) begin
               w_grant    = 1'b1;
               w_grant_sv = 1'b1;
            end else if (I_RD_REQ) begin
               w_grant = 1'b1;
               if (I_SV_REQ && (r_starve < C_STARVE))
                  w_starve_next = r_starve + 8'd1;
            end else if (I_SV_REQ) begin
               w_grant    = 1'b1;
               w_grant_sv = 1'b1;
            end
            if (w_grant_sv)
               w_starve_next = 8'd0;
            if (w_grant)
               w_next = S_ADDR;
         end
         S_ADDR:     w_next = r_is_wr ? S_WR_PULSE : S_RD_WAIT;
         S_RD_WAIT:  if (r_cnt == C_RD_LAST) w_next = S_RECOVER;
         S_WR_PULSE: if (r_cnt == C_WR_LAST) w_next = S_WR_HOLD;
         S_WR_HOLD:  w_next = S_RECOVER;
         S_RECOVER:  if (r_cnt == C_RC_LAST) w_next = S_IDLE;
         default:    w_next = S_IDLE;
      endcase
   end

   assign w_new_wr = w_grant_sv & I_SV_WE;
   assign w_sample = (r_state == S_RD_WAIT) && (w_next == S_RECOVER);

   always_ff @(posedge I_CLK or posedge I_RESET) begin
      if (I_RESET) begin
         r_state    <= S_IDLE;
         r_cnt      <= 8'd0;
         r_starve   <= 8'd0;
         r_is_sv    <= 1'b0;
         r_is_wr    <= 1'b0;
         r_addr     <= 24'd0;
         r_wdata    <= 16'd0;
         r_ce_l     <= 1'b1;
         r_oe_l     <= 1'b1;
         r_we_l     <= 1'b1;
         r_adv_l    <= 1'b1;
         r_drive    <= 1'b0;
         r_busy     <= 1'b0;
         r_rd_ack   <= 1'b0;
         r_sv_ack   <= 1'b0;
         r_rd_data  <= 16'd0;
         r_sv_rdata <= 16'd0;
      end else begin
         r_state  <= w_next;
         r_cnt    <= (w_next != r_state) ? 8'd0 : r_cnt + 8'd1;
         r_starve <= w_starve_next;
         if (w_grant) begin
            r_is_sv <= w_grant_sv;
            r_is_wr <= w_new_wr;
            r_addr  <= w_grant_sv ? I_SV_ADDR : I_RD_ADDR;
            r_wdata <= I_SV_WDATA;
         end
         // Strobes are decoded from the next state so every pin is a flop output.
         r_ce_l   <= !(w_next inside {S_ADDR, S_RD_WAIT, S_WR_PULSE, S_WR_HOLD});
         r_oe_l   <= (w_next != S_RD_WAIT);
         r_we_l   <= (w_next != S_WR_PULSE);
         r_adv_l  <= (w_next != S_ADDR);
         r_drive  <= ((w_next == S_ADDR) && w_new_wr) ||
                     (w_next == S_WR_PULSE) || (w_next == S_WR_HOLD);
         r_busy   <= (w_next != S_IDLE);
         r_rd_ack <= (w_next == S_RECOVER) && (r_state != S_RECOVER) && !r_is_sv;
         r_sv_ack <= (w_next == S_RECOVER) && (r_state != S_RECOVER) && r_is_sv;
         if (w_sample) begin
            if (r_is_sv)
               r_sv_rdata <= IO_FLASH_DATA;
            else
               r_rd_data <= IO_FLASH_DATA;
         end
      end
   end

   assign IO_FLASH_DATA  = r_drive ? r_wdata : 16'hzzzz;
   assign O_FLASH_ADDR   = r_addr;
   assign O_FLASH_CLK    = 1'b0;
   assign O_ADDR_VALID_L = r_adv_l;
   assign O_FLASH_CE_L   = r_ce_l;
   assign O_FLASH_OE_L   = r_oe_l;
   assign O_FLASH_WE_L   = r_we_l;
   assign O_BUSY         = r_busy;
   assign O_RD_DATA      = r_rd_data;
   assign O_RD_ACK       = r_rd_ack;
   assign O_SV_RDATA     = r_sv_rdata;
   assign O_SV_ACK       = r_sv_ack;

endmodule

// File: tb/tb_flash_arbiter.sv
// Bench for flash_arbiter: per-cycle strobe tables for single accesses, an ack scoreboard,
// and sequences for mid-access reset, starvation and back-to-back save streams.
module tb_flash_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rd_req = 1'b0, sv_req = 1'b0, sv_we = 1'b0;
   logic [23:0] rd_addr = '0, sv_addr = '0;
   logic [15:0] sv_wdata = '0;
   logic [15:0] rd_data, sv_rdata;
   logic        rd_ack, sv_ack;
   logic [23:0] flash_addr;
   logic        flash_clk, adv_l, ce_l, oe_l, we_l, busy;
   wire  [15:0] flash_bus;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   function automatic logic [15:0] flash_word(input logic [23:0] a);
      return a[15:0] ^ 16'hC2F5 ^ {8'h00, a[23:16]};
   endfunction

   // Flash model: drives the addressed word while chip and output enables are low.
   assign flash_bus = (!ce_l && !oe_l) ? flash_word(flash_addr) : 16'hzzzz;

   flash_arbiter dut (
      .I_CLK(clk), .I_RESET(rst),
      .I_RD_REQ(rd_req), .I_RD_ADDR(rd_addr), .O_RD_DATA(rd_data), .O_RD_ACK(rd_ack),
      .I_SV_REQ(sv_req), .I_SV_WE(sv_we), .I_SV_ADDR(sv_addr), .I_SV_WDATA(sv_wdata),
      .O_SV_RDATA(sv_rdata), .O_SV_ACK(sv_ack),
      .IO_FLASH_DATA(flash_bus), .O_FLASH_ADDR(flash_addr), .O_FLASH_CLK(flash_clk),
      .O_ADDR_VALID_L(adv_l), .O_FLASH_CE_L(ce_l), .O_FLASH_OE_L(oe_l),
      .O_FLASH_WE_L(we_l), .O_BUSY(busy)
   );

   typedef struct { bit wr; logic [15:0] d; } exp_t;
   exp_t rd_q[$];
   exp_t sv_q[$];

   typedef struct { logic ce_l, oe_l, we_l, adv_l, busy, ack, drv; } row_t;
   row_t rd_tab[8];
   row_t wr_tab[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: every ack must match the oldest outstanding expectation of its requester.
   initial begin
      forever begin
         exp_t e;
         @(posedge clk);
         #1;
         if (rd_ack) begin
            if (rd_q.size() == 0) chk("rd_ack_spurious", 1, 0);
            else begin
               e = rd_q.pop_front();
               chk("rd_data", rd_data, e.d);
            end
         end
         if (sv_ack) begin
            if (sv_q.size() == 0) chk("sv_ack_spurious", 1, 0);
            else begin
               e = sv_q.pop_front();
               if (!e.wr) chk("sv_rdata", sv_rdata, e.d);
            end
         end
         if (!oe_l && !we_l) chk("oe_we_overlap", 1, 0);
      end
   end

   task automatic run_single(input bit sv, input bit is_wr, input logic [23:0] a, input logic [15:0] d);
      row_t r;
      logic [6:0] exp_v;
      if (sv) begin
         sv_req = 1'b1; sv_we = is_wr; sv_addr = a; sv_wdata = d;
         sv_q.push_back('{is_wr, flash_word(a)});
      end else begin
         rd_req = 1'b1; rd_addr = a;
         rd_q.push_back('{1'b0, flash_word(a)});
      end
      for (int c = 0; c < 8; c++) begin
         if (is_wr) r = wr_tab[c];
         else       r = rd_tab[c];
         exp_v = {r.ce_l, r.oe_l, r.we_l, r.adv_l, r.busy, sv ? 1'b0 : r.ack, sv ? r.ack : 1'b0};
         chk($sformatf("strobes_%s%s_c%0d", sv ? "sv" : "rd", is_wr ? "w" : "r", c),
             {25'd0, ce_l, oe_l, we_l, adv_l, busy, rd_ack, sv_ack}, {25'd0, exp_v});
         if (r.drv) chk($sformatf("bus_wdata_c%0d", c), flash_bus, d);
         if (c == 1) chk("flash_addr", flash_addr, a);
         if (c == 6) begin
            rd_req = 1'b0;
            sv_req = 1'b0;
         end
         tick;
      end
   endtask

   initial begin
      bit ord[$];
      int t[$];
      int n;
      int acks;

      //                ce oe we adv busy ack drv
      rd_tab[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      rd_tab[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      for (int i = 2; i < 6; i++) rd_tab[i] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      rd_tab[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      rd_tab[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      wr_tab[0] = rd_tab[0];
      wr_tab[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      for (int i = 2; i < 5; i++) wr_tab[i] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      wr_tab[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      wr_tab[6] = rd_tab[6];
      wr_tab[7] = rd_tab[7];

      // Reset state
      tick; tick;
      chk("reset_strobes", {25'd0, ce_l, oe_l, we_l, adv_l, busy, rd_ack, sv_ack}, 32'h78);
      chk("reset_addr", flash_addr, 0);
      chk("reset_rd_data", rd_data, 0);
      chk("reset_sv_rdata", sv_rdata, 0);
      chk("flash_clk", flash_clk, 0);
      rst = 1'b0;
      tick;

      run_single(1'b0, 1'b0, 24'h000150, 16'h0000);
      chk("rd_data_c3a5", rd_data, 16'hC3A5);
      run_single(1'b1, 1'b1, 24'h7F0000, 16'h1234);
      run_single(1'b1, 1'b0, 24'h00ABCD, 16'h0000);
      run_single(1'b0, 1'b0, 24'h123456, 16'h0000);
      tick;
      chk("rd_q_drained", rd_q.size(), 0);
      chk("sv_q_drained", sv_q.size(), 0);

      // Reset in the middle of a read
      rd_req = 1'b1; rd_addr = 24'h000200;
      rd_q.push_back('{1'b0, flash_word(24'h000200)});
      tick; tick; tick;
      chk("midread_oe_low", oe_l, 0);
      #3 rst = 1'b1;
      #1;
      chk("midread_reset_strobes", {27'd0, ce_l, oe_l, we_l, adv_l, busy}, 32'h1E);
      chk("midread_reset_addr", flash_addr, 0);
      chk("midread_reset_rd_data", rd_data, 0);
      rd_q.delete();
      rd_req = 1'b0;
      tick;
      rst = 1'b0;
      acks = 0;
      for (int k = 0; k < 12; k++) begin
         tick;
         if (rd_ack) acks++;
      end
      chk("midread_no_ack", acks, 0);

      // Both requesters held continuously
      rd_req = 1'b1; rd_addr = 24'h001000;
      sv_req = 1'b1; sv_we = 1'b0; sv_addr = 24'h400000;
      rd_q.push_back('{1'b0, flash_word(rd_addr)});
      sv_q.push_back('{1'b0, flash_word(sv_addr)});
      n = 0;
      for (int k = 0; k < 400 && n < 18; k++) begin
         tick;
         if (rd_ack) begin
            ord.push_back(1'b0); n++;
            rd_addr = rd_addr + 24'd1;
            rd_q.push_back('{1'b0, flash_word(rd_addr)});
         end
         if (sv_ack) begin
            ord.push_back(1'b1); n++;
            sv_addr = sv_addr + 24'd1;
            sv_q.push_back('{1'b0, flash_word(sv_addr)});
         end
      end
      rd_req = 1'b0; sv_req = 1'b0;
      tick;
      rd_q.delete(); sv_q.delete();
      chk("starve_ack_count", n, 18);
      for (int i = 0; i < ord.size(); i++)
         chk($sformatf("grant_order_%0d", i), ord[i], (i % 9) == 8);
      repeat (8) tick;

      // Back-to-back save reads
      sv_req = 1'b1; sv_we = 1'b0; sv_addr = 24'h100000;
      sv_q.push_back('{1'b0, flash_word(sv_addr)});
      for (int k = 0; k < 100 && t.size() < 6; k++) begin
         tick;
         if (sv_ack) begin
            t.push_back(cyc);
            sv_addr = sv_addr + 24'd1;
            sv_q.push_back('{1'b0, flash_word(sv_addr)});
         end
      end
      sv_req = 1'b0;
      tick;
      sv_q.delete();
      chk("stream_ack_count", t.size(), 6);
      for (int i = 1; i < t.size(); i++)
         chk($sformatf("stream_period_%0d", i), t[i] - t[i-1], 7);
      repeat (10) tick;
      chk("final_idle", busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
